// File: rtl/tspp_types_pkg.sv
// Shared types for the TSPP memory arbiter: FSM state encoding, the latched
// bus request record and default sizing constants.
package tspp_types_pkg;

    localparam int unsigned ARB_ADDR_W              = 32;
    localparam int unsigned ARB_DATA_W              = 32;
    localparam int unsigned ARB_BE_W                = ARB_DATA_W / 8;
    localparam int unsigned DEFAULT_MAX_DATA_STREAK = 4;

    // Arbiter FSM states, explicitly encoded so waveforms and legacy tools agree.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DREQ = 2'd1,
        IREQ = 2'd2
    } arb_state_t;

    // One granted bus access, held stable for the whole transaction.
    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
        logic [ARB_BE_W-1:0]   byte_en;
        logic                  ren;
        logic                  wen;
    } arb_req_t;

endpackage

// File: rtl/tspp_memory_arbiter.sv
// Memory bus arbiter for the two-stage TSPP pipeline. Data accesses win by
// default; a saturating streak counter hands the bus to a waiting fetch after
// MAX_DATA_STREAK consecutive data grants. Each grant is latched and replayed
// onto the bus until out_busy drops, then the FSM takes one IDLE cycle so a
// still-asserted request is not re-issued for the access just completed.
// The request record width comes from tspp_types_pkg, so ADDR_W/DATA_W must
// match the package widths.
module tspp_memory_arbiter
    import tspp_types_pkg::*;
#(
    parameter int unsigned ADDR_W          = ARB_ADDR_W,
    parameter int unsigned DATA_W          = ARB_DATA_W,
    parameter int unsigned MAX_DATA_STREAK = DEFAULT_MAX_DATA_STREAK
) (
    input  logic                CLK,
    input  logic                nRST,
    // fetch port
    input  logic                iren,
    input  logic [ADDR_W-1:0]   iaddr,
    output logic                ibusy,
    output logic [DATA_W-1:0]   irdata,
    // data port
    input  logic                dren,
    input  logic                dwen,
    input  logic [ADDR_W-1:0]   daddr,
    input  logic [DATA_W-1:0]   dwdata,
    input  logic [DATA_W/8-1:0] dbyte_en,
    output logic                dbusy,
    output logic [DATA_W-1:0]   drdata,
    // memory bus
    output logic [ADDR_W-1:0]   out_addr,
    output logic                out_ren,
    output logic                out_wen,
    output logic [DATA_W-1:0]   out_wdata,
    output logic [DATA_W/8-1:0] out_byte_en,
    input  logic [DATA_W-1:0]   out_rdata,
    input  logic                out_busy
);

    localparam int unsigned          STREAK_W   = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0]  STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    arb_state_t          state_r;
    arb_state_t          next_state_s;
    arb_req_t            req_r;
    arb_req_t            req_next_s;
    logic [STREAK_W-1:0] streak_r;
    logic [STREAK_W-1:0] streak_next_s;
    logic                dpend_s;
    logic                fetch_due_s;
    logic                active_s;

    // Arbitration decision, request capture and streak bookkeeping.
    always_comb begin
        next_state_s  = state_r;
        req_next_s    = req_r;
        streak_next_s = streak_r;
        dpend_s       = dren | dwen;
        fetch_due_s   = iren && (streak_r == STREAK_MAX);
        case (state_r)
            IDLE: begin
                if (dpend_s && !fetch_due_s) begin
                    next_state_s       = DREQ;
                    req_next_s.addr    = daddr;
                    req_next_s.wdata   = dwdata;
                    req_next_s.byte_en = dbyte_en;
                    req_next_s.ren     = dren;
                    req_next_s.wen     = dwen;
                    if (iren && (streak_r != STREAK_MAX)) begin
                        streak_next_s = streak_r + STREAK_W'(1'b1);
                    end else if (iren) begin
                        streak_next_s = streak_r;
                    end else begin
                        streak_next_s = {STREAK_W{1'b0}};
                    end
                end else if (iren) begin
                    next_state_s       = IREQ;
                    req_next_s.addr    = iaddr;
                    req_next_s.wdata   = {DATA_W{1'b0}};
                    req_next_s.byte_en = {(DATA_W/8){1'b1}};
                    req_next_s.ren     = 1'b1;
                    req_next_s.wen     = 1'b0;
                    streak_next_s      = {STREAK_W{1'b0}};
                end else begin
                    next_state_s  = IDLE;
                    streak_next_s = {STREAK_W{1'b0}};
                end
            end
            DREQ, IREQ: begin
                if (!out_busy) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: begin
                next_state_s  = IDLE;
                streak_next_s = {STREAK_W{1'b0}};
            end
        endcase
    end

    // State, latched request and streak registers; reset abandons any access.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r  <= IDLE;
            req_r    <= '0;
            streak_r <= {STREAK_W{1'b0}};
        end else begin
            state_r  <= next_state_s;
            req_r    <= req_next_s;
            streak_r <= streak_next_s;
        end
    end

    // Bus drive comes only from registered state; a write beats a read.
    always_comb begin
        active_s    = (state_r != IDLE);
        out_addr    = req_r.addr;
        out_wdata   = req_r.wdata;
        out_byte_en = req_r.byte_en;
        if (active_s) begin
            out_wen = req_r.wen;
            out_ren = req_r.ren & ~req_r.wen;
        end else begin
            out_wen = 1'b0;
            out_ren = 1'b0;
        end
    end

    // Each busy drops only in its own completion cycle; read data flows through.
    always_comb begin
        ibusy  = ~((state_r == IREQ) && !out_busy);
        dbusy  = ~((state_r == DREQ) && !out_busy);
        irdata = out_rdata;
        drdata = out_rdata;
    end

endmodule
